// File: rtl/d_flip_flop.sv
// d_flip_flop: parameterisable D-type register / fixed-latency delay line.
// WIDTH bits wide, STAGES cascaded stages, async active-low reset to RESET_VALUE.
// Optional macro D_FLIP_FLOP_QN_EN adds out_data_n, the inverse of out_data,
// taken from the same final register.
module d_flip_flop #(
    parameter int              WIDTH       = 1,
    parameter int              STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
`ifdef D_FLIP_FLOP_QN_EN
    output logic [WIDTH-1:0] out_data_n,
`endif
    output logic [WIDTH-1:0] out_data
);

    // Reject degenerate configurations at elaboration.
    if (WIDTH < 1) begin : g_bad_width
        $error("d_flip_flop: WIDTH must be >= 1 (got %0d)", WIDTH);
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("d_flip_flop: STAGES must be >= 1 (got %0d)", STAGES);
    end

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    // Next-state: stage 0 takes the input, every later stage shifts from its predecessor.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_data;
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Stage registers; reset clears every in-flight value to RESET_VALUE immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= {STAGES{RESET_VALUE}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_data = stage_q[STAGES-1];

`ifdef D_FLIP_FLOP_QN_EN
    // Inverted output comes straight off the last register, so it tracks out_data with no added latency.
    assign out_data_n = ~stage_q[STAGES-1];
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed checks of d_flip_flop in two configurations,
// a 1-bit single-stage cell and an 8-bit 3-stage delay line with RESET_VALUE 8'hA5.
`timescale 1ns/1ps
module tb_d_flip_flop;

    typedef struct {
        logic       rst;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_a;
    logic       reset_b;
    logic [0:0] in_a;
    logic [0:0] out_a;
    logic [7:0] in_b;
    logic [7:0] out_b;
`ifdef D_FLIP_FLOP_QN_EN
    logic [0:0] out_n_a;
    logic [7:0] out_n_b;
`endif

    int total = 0;
    int bad   = 0;

    vec_t va[7];
    vec_t vb[10];

    always #100 clk = ~clk;

    d_flip_flop #(
        .WIDTH      (1),
        .STAGES     (1),
        .RESET_VALUE(1'b0)
    ) u_dut_a (
        .clk       (clk),
        .reset     (reset_a),
        .in_data   (in_a),
`ifdef D_FLIP_FLOP_QN_EN
        .out_data_n(out_n_a),
`endif
        .out_data  (out_a)
    );

    d_flip_flop #(
        .WIDTH      (8),
        .STAGES     (3),
        .RESET_VALUE(8'hA5)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .in_data   (in_b),
`ifdef D_FLIP_FLOP_QN_EN
        .out_data_n(out_n_b),
`endif
        .out_data  (out_b)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string name, input logic exp);
        chk(name, {7'b0, out_a}, {7'b0, exp});
`ifdef D_FLIP_FLOP_QN_EN
        chk({name, "_n"}, {7'b0, out_n_a}, {7'b0, ~exp});
`endif
    endtask

    task automatic chk_b(input string name, input logic [7:0] exp);
        chk(name, out_b, exp);
`ifdef D_FLIP_FLOP_QN_EN
        chk({name, "_n"}, out_n_b, ~exp);
`endif
    endtask

    initial begin
        // 1-bit cell: one vector per clock, expected out_data after that edge.
        va[0] = '{1'b1, 8'h00, 8'h00};
        va[1] = '{1'b1, 8'h01, 8'h01};
        va[2] = '{1'b1, 8'h01, 8'h01};
        va[3] = '{1'b1, 8'h00, 8'h00};
        va[4] = '{1'b0, 8'h01, 8'h00};
        va[5] = '{1'b1, 8'h01, 8'h01};
        va[6] = '{1'b1, 8'h00, 8'h00};
        // 3-stage 8-bit line: latency three edges, reset flushes everything back to A5.
        vb[0] = '{1'b1, 8'h01, 8'hA5};
        vb[1] = '{1'b1, 8'h02, 8'hA5};
        vb[2] = '{1'b1, 8'h03, 8'h01};
        vb[3] = '{1'b1, 8'h04, 8'h02};
        vb[4] = '{1'b1, 8'h05, 8'h03};
        vb[5] = '{1'b0, 8'hFF, 8'hA5};
        vb[6] = '{1'b1, 8'h10, 8'hA5};
        vb[7] = '{1'b1, 8'h20, 8'hA5};
        vb[8] = '{1'b1, 8'h30, 8'h10};
        vb[9] = '{1'b1, 8'h00, 8'h20};

        reset_a = 1'b1;
        reset_b = 1'b1;
        in_a    = 1'b1;
        in_b    = 8'h00;

        // Async reset with no clock edge yet (first rising edge is at t=100).
        #5;
        reset_a = 1'b0;
        reset_b = 1'b0;
        #5;
        chk_a("async_rst_no_clk_a", 1'b0);
        chk_b("async_rst_no_clk_b", 8'hA5);

        // Reset held across the t=100 edge with in_data=1.
        @(posedge clk); #1;
        chk_a("rst_held_edge_a", 1'b0);
        chk_b("rst_held_edge_b", 8'hA5);

        // Release at t=150, capture on t=300 edge.
        #49;
        reset_a = 1'b1;
        @(posedge clk); #1;
        chk_a("capture_after_release", 1'b1);

        #99;
        in_a = 1'b0;
        @(posedge clk); #1;
        chk_a("capture_zero", 1'b0);

        // Mid-cycle toggles of in_data must not reach out_data.
        in_a = 1'b1;
        @(posedge clk); #1;
        chk_a("capture_one", 1'b1);
        #50;
        in_a = 1'b0;
        #1;
        chk_a("no_comb_path_lo", 1'b1);
        #49;
        in_a = 1'b1;
        #1;
        chk_a("no_comb_path_hi", 1'b1);
        @(posedge clk); #1;
        chk_a("edge_value_sampled", 1'b1);

        // Async reset mid-cycle while out_data=1, held across an edge, then released.
        #49;
        reset_a = 1'b0;
        #1;
        chk_a("async_rst_midcycle", 1'b0);
        in_a = 1'b1;
        @(posedge clk); #1;
        chk_a("rst_across_edge", 1'b0);
        chk_b("b_still_in_reset", 8'hA5);
        #49;
        reset_a = 1'b1;
        @(posedge clk); #1;
        chk_a("capture_after_rst_edge", 1'b1);

        // Table for the 1-bit cell: drive on falling edge, check just after rising edge.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            reset_a = va[i].rst;
            in_a    = va[i].din[0];
            @(posedge clk); #1;
            chk_a($sformatf("vec_a[%0d]", i), va[i].exp[0]);
        end

        // Table for the 3-stage line.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            reset_b = vb[i].rst;
            in_b    = vb[i].din;
            @(posedge clk); #1;
            chk_b($sformatf("vec_b[%0d]", i), vb[i].exp);
        end

        // Async reset on the pipeline flushes in-flight data without a clock edge.
        #50;
        reset_b = 1'b0;
        #1;
        chk_b("async_rst_pipe", 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
